// File: rtl/booth_mul_seq_if.sv
// rtl/booth_mul_seq_if.sv - start/done handshake and operand/product bundle for booth_mul_seq
interface booth_mul_seq_if #(
  parameter int WIDTH = 8
);
  logic                   start;
  logic [WIDTH-1:0]       a;
  logic [WIDTH-1:0]       b;
  logic                   busy;
  logic                   done;
  logic [2*WIDTH-1:0]     m;

  modport master (
    output start, a, b,
    input  busy, done, m
  );

  modport slave (
    input  start, a, b,
    output busy, done, m
  );
endinterface

// File: rtl/booth_mul_seq.sv
// rtl/booth_mul_seq.sv - sequential radix-2 Booth multiplier; optional early exit under BOOTH_EARLY_EXIT_EN
module booth_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  booth_mul_seq_if.slave   bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state_q, state_d;
  logic [WIDTH:0]       acc_q, acc_d;
  logic [WIDTH:0]       mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplr_q, mplr_d;
  logic                 q1_q, q1_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;

  logic [WIDTH:0]       sum;
  logic [WIDTH:0]       acc_sh;
  logic [WIDTH-1:0]     mplr_sh;
  logic                 q1_sh;
  logic [CW-1:0]        cnt_dec;
  logic                 finish;
  logic [2*WIDTH-1:0]   result;
`ifdef BOOTH_EARLY_EXIT_EN
  logic signed [2*WIDTH:0] full_sh;
`endif

  // One Booth step: add/subtract the multiplicand, then arithmetic-shift {A,Q,q_1}
  always_comb begin
    case ({mplr_q[0], q1_q})
      2'b01:   sum = acc_q + mcand_q;
      2'b10:   sum = acc_q - mcand_q;
      default: sum = acc_q;
    endcase
    acc_sh  = {sum[WIDTH], sum[WIDTH:1]};
    mplr_sh = {sum[0], mplr_q[WIDTH-1:1]};
    q1_sh   = mplr_q[0];
    cnt_dec = cnt_q - 1'b1;
`ifdef BOOTH_EARLY_EXIT_EN
    // After this step, stop if every remaining Booth pair is 00 or 11; the
    // outstanding shifts collapse into one arithmetic shift by the count left.
    finish = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      if (i < int'(cnt_dec) && mplr_sh[i] != q1_sh) begin
        finish = 1'b0;
      end
    end
    full_sh = $signed({acc_sh, mplr_sh}) >>> cnt_dec;
    result  = full_sh[2*WIDTH-1:0];
`else
    finish = (cnt_dec == '0);
    result = {acc_sh[WIDTH-1:0], mplr_sh};
`endif
  end

  // Next-state: load operands when idle, step while running, publish on the last step
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    q1_d    = q1_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    prod_d  = prod_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          acc_d   = '0;
          mcand_d = {bus.a[WIDTH-1], bus.a};
          mplr_d  = bus.b;
          q1_d    = 1'b0;
          cnt_d   = CW'(WIDTH);
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d  = acc_sh;
        mplr_d = mplr_sh;
        q1_d   = q1_sh;
        cnt_d  = cnt_dec;
        if (finish) begin
          cnt_d   = '0;
          prod_d  = result;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
    endcase
  end

  // State registers with synchronous reset; reset aborts any operation in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
      q1_q    <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      q1_q    <= q1_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      prod_q  <= prod_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.m    = prod_q;
endmodule
